// File: rtl/hist_pkg.sv
// hist_pkg -- shared definitions for the histogram-feed controller.
//   hist_state_e : controller states (IDLE, RUN, DRAIN, DONE)
//   WORD_W_DEF   : default pixel-word width fed to the histogram memory
//   ADDR_W_DEF   : default source-memory word-address width
//   NUM_BINS     : number of bins in the downstream histogram memory
package hist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hist_state_e;

  localparam int WORD_W_DEF = 128;
  localparam int ADDR_W_DEF = 16;
  localparam int NUM_BINS   = 256;

endpackage

// File: rtl/hist_pipe.sv
// hist_pipe -- two-stage valid/data pipeline between the source-memory
// read strobe and the histogram-memory accumulate enable.
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset, clears both valid stages
//   rd_issue_i : a source read is issued this cycle
//   rdata_i    : source read data (valid the cycle after rd_issue_i)
//   rd_vld_o   : stage-1 valid, read data is on rdata_i this cycle
//   hist_we_o  : stage-2 valid, accumulate enable to the histogram memory
//   hist_a_o   : registered pixel word, holds when hist_we_o is low
module hist_pipe #(
  parameter int WORD_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic              rd_vld_o,
  output logic              hist_we_o,
  output logic [WORD_W-1:0] hist_a_o
);

  logic              rd_vld_q,  rd_vld_d;
  logic              hist_we_q, hist_we_d;
  logic [WORD_W-1:0] hist_a_q,  hist_a_d;

  always_comb begin
    rd_vld_d  = rd_issue_i;
    hist_we_d = rd_vld_q;
    hist_a_d  = hist_a_q;
    if (rd_vld_q) begin
      hist_a_d = rdata_i;
    end
  end

  // hist_a/hist_we change only on posedge, so they are settled when the
  // histogram memory samples them on negedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      hist_we_q <= 1'b0;
      hist_a_q  <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      hist_we_q <= hist_we_d;
      hist_a_q  <= hist_a_d;
    end
  end

  assign rd_vld_o  = rd_vld_q;
  assign hist_we_o = hist_we_q;
  assign hist_a_o  = hist_a_q;

endmodule

// File: rtl/hist_ctrl.sv
// hist_ctrl -- streams num_words pixel words from a synchronous-read source
// memory into a histogram memory, one word per cycle.
//   clk       : clock, all state on posedge
//   rst       : synchronous active-high reset, aborts any job
//   start     : job request, honoured only in IDLE
//   base_addr : first source word address, captured with start
//   num_words : number of words to process, captured with start
//   src_re    : source read strobe
//   src_addr  : source read address, wraps modulo 2^ADDR_W
//   src_rdata : source read data, one cycle after src_re
//   hist_we   : histogram accumulate enable (sampled on negedge downstream)
//   hist_a    : pixel word to the histogram memory
//   busy      : job in progress (RUN or DRAIN)
//   done      : one-cycle completion pulse
//   cycle_cnt : busy-cycle count of the last job
// Optional build macro: HIST_CYCLE_CNT_EN enables the busy-cycle counter;
// without it cycle_cnt is constant 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one source read per cycle, words_left counting down
// DRAIN | reads finished, waiting for the pipeline to empty
// DONE  | one-cycle done pulse, then back to IDLE
module hist_ctrl
  import hist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              src_re,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [WORD_W-1:0] src_rdata,
  output logic              hist_we,
  output logic [WORD_W-1:0] hist_a,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycle_cnt
);

  hist_state_e       state_q, state_d;
  logic              src_re_q, src_re_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] words_left_q, words_left_d;
  logic              start_acc;
  logic              rd_vld;

  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    state_d      = state_q;
    src_re_d     = src_re_q;
    src_addr_d   = src_addr_q;
    words_left_d = words_left_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          if (num_words != '0) begin
            state_d      = RUN;
            src_re_d     = 1'b1;
            src_addr_d   = base_addr;
            words_left_d = num_words;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        words_left_d = words_left_q - ADDR_W'(1);
        // Terminal count: the read in this cycle is the last one, so the
        // address stays on it rather than advancing.
        if (words_left_q == ADDR_W'(1)) begin
          state_d  = DRAIN;
          src_re_d = 1'b0;
        end else begin
          src_addr_d = src_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // With stage 1 empty, the word in stage 2 (if any) is written this
        // cycle, so the pipeline is empty after this edge.
        if (!rd_vld) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        src_re_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_re_q     <= 1'b0;
      src_addr_q   <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      src_re_q     <= src_re_d;
      src_addr_q   <= src_addr_d;
      words_left_q <= words_left_d;
    end
  end

  hist_pipe #(
    .WORD_W (WORD_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .rd_issue_i (src_re_q),
    .rdata_i    (src_rdata),
    .rd_vld_o   (rd_vld),
    .hist_we_o  (hist_we),
    .hist_a_o   (hist_a)
  );

  assign src_re   = src_re_q;
  assign src_addr = src_addr_q;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

`ifdef HIST_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (start_acc) begin
      cyc_d = '0;
    end else if (busy) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: doc/hist_ctrl.md
HIST_CTRL -- requirements
Module: hist_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the source-memory word-address width.
REQ-002 The block SHALL have parameter WORD_W, default 128, giving the pixel-word width fed to the histogram memory.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, a request to histogram one image block, sampled only in IDLE.
REQ-006 The block SHALL have port base_addr, input, ADDR_W, the first source word address, captured with start.
REQ-007 The block SHALL have port num_words, input, ADDR_W, the number of WORD_W words to process, captured with start.
REQ-008 The block SHALL have port src_re, output, 1, the source-memory read strobe.
REQ-009 The block SHALL have port src_addr, output, ADDR_W, the source-memory read address.
REQ-010 The block SHALL have port src_rdata, input, WORD_W, the source read data, valid one cycle after src_re (synchronous read).
REQ-011 The block SHALL have port hist_we, output, 1, the histogram-memory accumulate enable; the histogram memory samples it on negedge clk.
REQ-012 The block SHALL have port hist_a, output, WORD_W, the pixel word presented to the histogram memory.
REQ-013 The block SHALL have port busy, output, 1, high from the start-accept edge until done.
REQ-014 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-015 The block SHALL have port cycle_cnt, output, 32, the busy-cycle count (see Configuration).

Function
REQ-016 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE with start=1 and num_words>0, the block SHALL capture base_addr and num_words and go to RUN on the same edge (edge e0).
REQ-018 In IDLE with start=1 and num_words=0, the block SHALL go directly to DONE, issuing no src_re and no hist_we.
REQ-019 In RUN, the block SHALL hold src_re=1 each cycle and increment src_addr by 1 per cycle from base_addr.
REQ-020 The block SHALL issue exactly num_words reads, in cycles 0..N-1 after e0, then go to DRAIN.
REQ-021 The block SHALL register src_rdata into hist_a one cycle after each read, with hist_we=1 in that same cycle.
REQ-022 As a result, word k SHALL appear on hist_a/hist_we in cycle k+2, giving a throughput of one word per cycle with no bubbles.
REQ-023 hist_a and hist_we SHALL be posedge registers only, so they are stable at the histogram memory's negedge sample.
REQ-024 DRAIN SHALL last until both in-flight pipeline stages are empty, then the block SHALL go to DONE.
REQ-025 For N>0, the last hist_we SHALL occur in cycle N+1 and done=1 in cycle N+2.
REQ-026 DONE SHALL last one cycle, then the block SHALL return to IDLE; busy=0 in DONE and IDLE.
REQ-027 start asserted in any state other than IDLE SHALL be ignored, with no queueing.
REQ-028 src_addr SHALL wrap modulo 2^ADDR_W; the wrap is not an error.
REQ-029 The internal word counter SHALL be ADDR_W bits; num_words=2^ADDR_W-1 is the maximum transfer.
REQ-030 When not reading, src_re SHALL be 0 and src_addr SHALL hold its last value.
REQ-031 When hist_we=0, hist_a SHALL hold its last value.

Reset
REQ-032 On rst=1 at a posedge, the block SHALL set state=IDLE, src_re=0, src_addr=0, hist_we=0, hist_a=0, busy=0, done=0, cycle_cnt=0 and clear the pipeline valid bits.
REQ-033 Reset mid-RUN or mid-DRAIN SHALL abort immediately; in-flight words are discarded, and no hist_we occurs in the cycle after the reset edge.
REQ-034 rst SHALL take priority over start on the same edge.

Configuration
REQ-035 With macro HIST_CYCLE_CNT_EN defined, cycle_cnt SHALL clear on the start-accept edge and increment once per busy cycle.
REQ-036 With HIST_CYCLE_CNT_EN defined, cycle_cnt SHALL hold its value after done until the next accepted start, and equal N+2 after a transfer of N>0 words.
REQ-037 Without HIST_CYCLE_CNT_EN, cycle_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-038 Package hist_pkg SHALL hold the state enum (IDLE, RUN, DRAIN, DONE), WORD_W_DEF=128, ADDR_W_DEF=16 and NUM_BINS=256.
REQ-039 Sub-module hist_pipe SHALL implement the two-stage valid/data pipeline (read-valid to hist_we); the FSM and counters SHALL stay in hist_ctrl.

Verification
REQ-040 Scenario: start with base_addr=0x0010, num_words=4 -> src_re in cycles 0-3 with addresses 0x10-0x13; hist_we in cycles 2-5 carrying the words in order; done in cycle 6; busy in cycles 0-5.
REQ-041 Scenario: num_words=0 -> no src_re and no hist_we; done in the cycle after e0.
REQ-042 Scenario: base_addr=0xFFFE, num_words=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-043 Scenario: start pulsed again during RUN of an 8-word job -> exactly 8 hist_we, with one done.
REQ-044 Scenario: rst asserted in cycle 3 of a 10-word job -> all outputs 0 the next cycle, no further hist_we, and IDLE accepts a new start.
REQ-045 Scenario: with HIST_CYCLE_CNT_EN defined and a 16-word job -> cycle_cnt=18 after done; without the macro, cycle_cnt=0 throughout.
